// File: rtl/traffic_uldl_pkg.sv
// Shared constants for the multi-channel UL/DL traffic generator:
// direction mode encodings and the 16-bit LFSR seed table and taps.
package traffic_uldl_pkg;

    localparam int LFSR_W = 16;

    typedef enum logic [1:0] {
        MODE_UL   = 2'b00,
        MODE_DL   = 2'b01,
        MODE_ALT  = 2'b10,
        MODE_RAND = 2'b11
    } mode_e;

    localparam logic [3:0][LFSR_W-1:0] LFSR_SEED = {
        16'h0001, 16'hBEEF, 16'h1D2B, 16'hACE1
    };

    // Taps 16,14,13,11 of a right-shifting Fibonacci register
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

    function automatic logic [LFSR_W-1:0] lfsr_step(
        input logic [LFSR_W-1:0] s
    );
        return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/traffic_uldl_multi_gen_timer.sv
// Per-channel period timer: fires once every P enabled cycles.
// A zero period disables the channel and parks the counter at 0.
module traffic_ch_timer #(
    parameter int PERIOD_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [PERIOD_W-1:0] i_period,
    output logic                o_fire
);

    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] cnt_d;
    logic                at_end;

    // >= rather than == so a shrunk period fires on the next cycle
    assign at_end = (i_period != '0)
                 && (cnt_q >= i_period - PERIOD_W'(1));
    assign o_fire = ena & at_end;

    // Next count: hold when frozen, wrap to 0 after firing
    always_comb begin
        cnt_d = cnt_q;
        if (i_period == '0) begin
            cnt_d = '0;
        end else if (ena) begin
            cnt_d = at_end ? '0 : cnt_q + PERIOD_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_uldl_multi_gen.sv
// Multi-channel UL/DL packet generator with round-robin arbitration.
// Optional TRAFFIC_DROP_CNT_EN adds a saturating dropped-request counter.
module traffic_uldl_multi_gen
    import traffic_uldl_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int PERIOD_W = 4,
    parameter int ID_W     = 8,
    parameter int CH_W     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic [1:0]                 i_mode,
    input  logic [1:0]                 i_seed_sel,
    input  logic [NUM_CH*PERIOD_W-1:0] i_cfg_period,
    input  logic                       i_pkt_ready,
    output logic                       o_pkt_valid,
    output logic [ID_W-1:0]            o_pkt_id,
    output logic [CH_W-1:0]            o_pkt_ch,
    output logic                       o_pkt_dir_dl,
    output logic                       o_pkt_pulse
`ifdef TRAFFIC_DROP_CNT_EN
    ,
    output logic [15:0]                o_drop_cnt
`endif
);

    logic [NUM_CH-1:0] fire;
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] pend_d;
    logic [NUM_CH-1:0] gnt_oh;
    logic [CH_W-1:0]   ptr_q;
    logic [CH_W-1:0]   ptr_d;
    logic [CH_W-1:0]   gnt_ch;
    logic              gnt_vld;
    logic              slot_free;
    logic              dir_sel;
    logic              alt_q;
    logic [LFSR_W-1:0] lfsr_q;
    logic [ID_W-1:0]   ul_id_q;
    logic [ID_W-1:0]   dl_id_q;
    logic              valid_q;
    logic [ID_W-1:0]   id_q;
    logic [CH_W-1:0]   ch_q;
    logic              dir_q;
    logic              pulse_q;
    int                arb_idx;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        traffic_ch_timer #(
            .PERIOD_W (PERIOD_W)
        ) u_tmr (
            .clk      (clk),
            .rst      (rst),
            .ena      (ena),
            .i_period (i_cfg_period[k*PERIOD_W +: PERIOD_W]),
            .o_fire   (fire[k])
        );
    end

    assign slot_free = !valid_q | i_pkt_ready;

    // Round-robin pick: first pending channel at or after the pointer
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        arb_idx = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            arb_idx = (int'(ptr_q) + i) % NUM_CH;
            for (int k = 0; k < NUM_CH; k++) begin
                if (slot_free && !gnt_vld
                    && k == arb_idx && pend_q[k]) begin
                    gnt_vld = 1'b1;
                    gnt_ch  = CH_W'(k);
                end
            end
        end
    end

    // Grant one-hot, pending and pointer next state
    always_comb begin
        gnt_oh = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            gnt_oh[k] = gnt_vld && (gnt_ch == CH_W'(k));
        end
        // A fire on a still-pending channel is lost unless it is granted now
        pend_d = fire | (pend_q & ~gnt_oh);
        ptr_d  = ptr_q;
        if (gnt_vld) begin
            ptr_d = (gnt_ch == CH_W'(NUM_CH - 1))
                  ? '0 : gnt_ch + CH_W'(1);
        end
    end

    // Direction of the packet being granted this cycle
    always_comb begin
        dir_sel = 1'b0;
        unique case (mode_e'(i_mode))
            MODE_UL:   dir_sel = 1'b0;
            MODE_DL:   dir_sel = 1'b1;
            MODE_ALT:  dir_sel = alt_q;
            MODE_RAND: dir_sel = lfsr_q[0];
        endcase
    end

    // Pending flags and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            ptr_q  <= '0;
        end else begin
            pend_q <= pend_d;
            ptr_q  <= ptr_d;
        end
    end

    // LFSR: reseeded while in reset, frozen when not enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED[i_seed_sel];
        end else if (ena) begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    // Output register, sequence counters and alternate toggle
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            id_q    <= '0;
            ch_q    <= '0;
            dir_q   <= 1'b0;
            pulse_q <= 1'b0;
            ul_id_q <= '0;
            dl_id_q <= '0;
            alt_q   <= 1'b0;
        end else begin
            pulse_q <= valid_q & i_pkt_ready;
            if (gnt_vld) begin
                valid_q <= 1'b1;
                ch_q    <= gnt_ch;
                dir_q   <= dir_sel;
                id_q    <= dir_sel ? dl_id_q : ul_id_q;
                if (dir_sel) begin
                    dl_id_q <= dl_id_q + ID_W'(1);
                end else begin
                    ul_id_q <= ul_id_q + ID_W'(1);
                end
                if (mode_e'(i_mode) == MODE_ALT) begin
                    alt_q <= ~alt_q;
                end
            end else if (i_pkt_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign o_pkt_valid  = valid_q;
    assign o_pkt_id     = id_q;
    assign o_pkt_ch     = ch_q;
    assign o_pkt_dir_dl = dir_q;
    assign o_pkt_pulse  = pulse_q;

`ifdef TRAFFIC_DROP_CNT_EN
    localparam int DN_W = $clog2(NUM_CH + 1);

    logic [NUM_CH-1:0] drop_vec;
    logic [DN_W-1:0]   drop_n;
    logic [16:0]       drop_sum;
    logic [15:0]       drop_q;

    // Count requests lost on already-pending, ungranted channels
    always_comb begin
        drop_vec = fire & pend_q & ~gnt_oh;
        drop_n   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            drop_n = drop_n + DN_W'(drop_vec[k]);
        end
        drop_sum = {1'b0, drop_q} + 17'(drop_n);
    end

    // Saturating drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else if (drop_sum[16]) begin
            drop_q <= 16'hFFFF;
        end else begin
            drop_q <= drop_sum[15:0];
        end
    end

    assign o_drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_traffic_uldl_multi_gen.sv
// Directed bench for traffic_uldl_multi_gen with a packet scoreboard.
// Optional TRAFFIC_DROP_CNT_EN also checks the drop counter.
module tb_traffic_uldl_multi_gen;

    localparam int NUM_CH   = 4;
    localparam int PERIOD_W = 4;
    localparam int ID_W     = 8;
    localparam int CH_W     = 2;

    typedef struct packed {
        logic            dir;
        logic [CH_W-1:0] ch;
        logic [ID_W-1:0] id;
    } pkt_t;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       ena;
    logic [1:0]                 mode;
    logic [1:0]                 seed_sel;
    logic [NUM_CH*PERIOD_W-1:0] cfg;
    logic                       ready;
    logic                       valid;
    logic [ID_W-1:0]            id;
    logic [CH_W-1:0]            ch;
    logic                       dir;
    logic                       pulse;
`ifdef TRAFFIC_DROP_CNT_EN
    logic [15:0]                drop_cnt;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    pkt_t sb_q[$];

    always #5 clk = ~clk;

    traffic_uldl_multi_gen #(
        .NUM_CH   (NUM_CH),
        .PERIOD_W (PERIOD_W),
        .ID_W     (ID_W),
        .CH_W     (CH_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .i_mode       (mode),
        .i_seed_sel   (seed_sel),
        .i_cfg_period (cfg),
        .i_pkt_ready  (ready),
        .o_pkt_valid  (valid),
        .o_pkt_id     (id),
        .o_pkt_ch     (ch),
        .o_pkt_dir_dl (dir),
        .o_pkt_pulse  (pulse)
`ifdef TRAFFIC_DROP_CNT_EN
        ,
        .o_drop_cnt   (drop_cnt)
`endif
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic d, input int c, input int i);
        pkt_t p;
        p.dir = d;
        p.ch  = CH_W'(c);
        p.id  = ID_W'(i);
        sb_q.push_back(p);
    endtask

    task automatic sb_pop_check();
        pkt_t got;
        pkt_t exp;
        got.dir = dir;
        got.ch  = ch;
        got.id  = id;
        if (sb_q.size() == 0) begin
            check("sb_unexpected", 32'(got), 32'hFFFF_FFFF);
        end else begin
            exp = sb_q.pop_front();
            check("sb_pkt", 32'(got), 32'(exp));
        end
    endtask

    // Score the transfer that completes at the coming edge, then advance
    task automatic tick();
        if (mon_en && valid && ready) sb_pop_check();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit chk);
        rst    = 1'b1;
        mon_en = 1'b0;
        sb_q.delete();
        tick();
        tick();
        if (chk) begin
            check("rst_valid", 32'(valid), 0);
            check("rst_id",    32'(id),    0);
            check("rst_ch",    32'(ch),    0);
            check("rst_dir",   32'(dir),   0);
            check("rst_pulse", 32'(pulse), 0);
`ifdef TRAFFIC_DROP_CNT_EN
            check("rst_drop",  32'(drop_cnt), 0);
`endif
        end
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!valid && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(valid), 1);
    endtask

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    task automatic run_rand(input logic [1:0] sel, input logic [15:0] seed);
        logic [15:0] s;
        int ul;
        int dl;
        mode     = 2'b11;
        seed_sel = sel;
        cfg      = 16'h1111;
        ready    = 1'b1;
        do_reset(1'b0);
        s  = seed;
        ul = 0;
        dl = 0;
        for (int n = 0; n < 16; n++) begin
            s = ref_step(s);
            sb_push(s[0], n % 4, s[0] ? dl : ul);
            if (s[0]) dl++;
            else ul++;
        end
        mon_en = 1'b1;
        wait_valid("t4_first");
        repeat (16) tick();
        mon_en = 1'b0;
        check("t4_drain", 32'(sb_q.size()), 0);
    endtask

    initial begin
        rst      = 1'b1;
        ena      = 1'b1;
        mode     = 2'b00;
        seed_sel = 2'b00;
        cfg      = '0;
        ready    = 1'b1;

        // 1: single channel P=4, UL only
        cfg = 16'h0004;
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) sb_push(1'b0, 0, i);
        mon_en = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            check("t1_valid", 32'(valid),
                  32'(c >= 6 && (c - 6) % 4 == 0));
            check("t1_pulse", 32'(pulse),
                  32'(c >= 7 && (c - 7) % 4 == 0));
            tick();
        end
        cfg = '0;
        repeat (5) tick();
        check("t1_idle", 32'(valid), 0);
        check("t1_drain", 32'(sb_q.size()), 0);

        // 2: all channels P=1, alternate direction
        mode = 2'b10;
        cfg  = 16'h1111;
        do_reset(1'b0);
        for (int n = 0; n < 12; n++) sb_push(1'(n % 2), n % 4, n / 2);
        mon_en = 1'b1;
        wait_valid("t2_first");
        repeat (12) tick();
        mon_en = 1'b0;
        check("t2_drain", 32'(sb_q.size()), 0);

        // 3: backpressure holds packet, later fires dropped
        mode  = 2'b00;
        cfg   = 16'h0002;
        ready = 1'b0;
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) sb_push(1'b0, 0, i);
        mon_en = 1'b1;
        repeat (3) tick();
        for (int c = 4; c <= 13; c++) begin
            check("t3_hold_valid", 32'(valid), 1);
            check("t3_hold_pkt", 32'({dir, ch, id}), 0);
            tick();
        end
        ready = 1'b1;
`ifdef TRAFFIC_DROP_CNT_EN
        check("t3_drop_cnt", 32'(drop_cnt), 4);
`endif
        repeat (5) tick();
        cfg = '0;
        repeat (6) tick();
        check("t3_idle", 32'(valid), 0);
        check("t3_drain", 32'(sb_q.size()), 0);

        // 4: random direction from two seeds
        run_rand(2'd0, 16'hACE1);
        run_rand(2'd3, 16'h0001);

        // 5: DL id wrap, then UL counter still at 0
        mode     = 2'b01;
        seed_sel = 2'b00;
        cfg      = 16'h1111;
        ready    = 1'b1;
        do_reset(1'b0);
        for (int n = 0; n < 260; n++) sb_push(1'b1, n % 4, n % 256);
        for (int n = 260; n < 264; n++) sb_push(1'b0, n % 4, n - 260);
        mon_en = 1'b1;
        wait_valid("t5_first");
        for (int k = 0; k < 264; k++) begin
            if (k == 259) mode = 2'b00;
            tick();
        end
        mon_en = 1'b0;
        check("t5_drain", 32'(sb_q.size()), 0);

        // 6: reset while a packet is held and channels pending
        mode = 2'b10;
        cfg  = 16'h1111;
        do_reset(1'b0);
        repeat (5) tick();
        ready = 1'b0;
        repeat (3) tick();
        check("t6_pre_valid", 32'(valid), 1);
        rst = 1'b1;
        cfg = '0;
        tick();
        check("t6_valid", 32'(valid), 0);
        check("t6_pkt", 32'({dir, ch, id}), 0);
        check("t6_pulse", 32'(pulse), 0);
        rst   = 1'b0;
        ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("t6_no_pend", 32'(valid), 0);
            tick();
        end
        cfg = 16'h1111;
        sb_push(1'b0, 0, 0);
        sb_push(1'b1, 1, 0);
        sb_push(1'b0, 2, 1);
        sb_push(1'b1, 3, 1);
        mon_en = 1'b1;
        wait_valid("t6_first");
        repeat (4) tick();
        mon_en = 1'b0;
        check("t6_drain", 32'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
